// File: rtl/im_loader_pkg.sv
// im_loader_pkg
// Shared definitions for the instruction-memory loader:
//   state_t        - loader state encoding (LOAD, RUN, ERR)
//   BYTES_PER_WORD - bytes assembled into one 32-bit instruction word
//   NOP_WORD       - value returned for unloaded or out-of-range addresses
package im_loader_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] NOP_WORD       = 32'h0;

endpackage

// File: rtl/im_word_assembler.sv
// im_word_assembler
// Collects big-endian bytes into 32-bit words. A word is emitted
// combinationally on the fourth byte, or early on a byte marked last, in
// which case the missing low bytes are zero.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   clear        - synchronous restart (discards any partial word)
//   byte_valid   - a byte is being consumed this cycle
//   byte_data    - the byte (first byte of a word lands in bits 31:24)
//   byte_last    - the byte is the final byte of the image
//   word_valid   - a complete (or padded) word is available this cycle
//   word_data    - the word being emitted
module im_word_assembler
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [23:0] assembly;
    logic [1:0]  byte_cnt;

    // The incoming byte is appended to the bytes already collected and the
    // remainder of the word is padded with zeros, so an early last byte
    // produces a correctly left-aligned word.
    always_comb begin
        word_valid = byte_valid && ((byte_cnt == 2'(BYTES_PER_WORD - 1)) || byte_last);
        case (byte_cnt)
            2'd0:    word_data = {byte_data, 24'h0};
            2'd1:    word_data = {assembly[7:0], byte_data, 16'h0};
            2'd2:    word_data = {assembly[15:0], byte_data, 8'h0};
            default: word_data = {assembly, byte_data};
        endcase
    end

    // A finished word empties the assembler so the next byte starts a fresh
    // word at bits 31:24.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            assembly <= 24'h0;
            byte_cnt <= 2'd0;
        end else if (word_valid) begin
            assembly <= 24'h0;
            byte_cnt <= 2'd0;
        end else if (byte_valid) begin
            assembly <= {assembly[15:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/im_loader.sv
// im_loader
// Instruction memory for a single-cycle core. The program image arrives as
// a byte stream (valid/ready); while loading, the core is held in reset.
// Once the image is complete (last byte or memory full) the core is
// released and instructions are read combinationally from IM_Address.
// Optional feature macro: IM_LOADER_CHECKSUM_EN - the byte after the last
// image byte is a checksum; a bad sum parks the loader in ERR (chk_err=1).
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   load_valid    - load byte present
//   load_data     - load byte (big-endian within a word)
//   load_last     - final image byte
//   load_ready    - byte accepted this cycle when load_valid is high
//   reload        - in RUN, restart loading
//   IM_Address    - word address from the core
//   Instruction   - instruction at IM_Address, or 0 if not loaded
//   cpu_rst       - core reset, high except in RUN
//   load_done     - high in RUN
//   words_loaded  - number of valid words stored
//   chk_err       - (checksum build only) high in ERR
module im_loader
    import im_loader_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic        reload,
    input  logic [15:0] IM_Address,
    output logic [31:0] Instruction,
    output logic        cpu_rst,
    output logic        load_done,
    output logic [AW:0] words_loaded
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    output logic        chk_err
`endif
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LAST_SLOT = (AW + 1)'(DEPTH - 1);

    state_t      state;
    state_t      state_next;
    logic        clear;
    logic        accept;
    logic        image_byte;
    logic        word_valid;
    logic [31:0] word_data;
    logic [31:0] mem [DEPTH];

`ifdef IM_LOADER_CHECKSUM_EN
    logic        chk_pending;
    logic [7:0]  sum;

    // Bytes keep flowing after the last image byte so the checksum can be
    // taken even when the image exactly filled the memory.
    assign load_ready = (state == LOAD) && ((words_loaded < DEPTH_W) || chk_pending);
    assign image_byte = accept && !chk_pending;
`else
    assign load_ready = (state == LOAD) && (words_loaded < DEPTH_W);
    assign image_byte = accept;
`endif

    assign accept = load_valid && load_ready;

    im_word_assembler u_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .byte_valid (image_byte),
        .byte_data  (load_data),
        .byte_last  (load_last),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The end of the image (last byte or the write that
    // fills the memory) moves straight to RUN; with checksums enabled the
    // last byte instead arms the checksum check, and the following byte
    // decides between RUN and ERR. Leaving RUN/ERR via reload also clears
    // the store bookkeeping.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        cpu_rst    = 1'b1;
        load_done  = 1'b0;
        case (state)
            LOAD: begin
`ifdef IM_LOADER_CHECKSUM_EN
                if (accept && chk_pending) begin
                    state_next = (8'(sum + load_data) == 8'h00) ? RUN : ERR;
                end else if (word_valid && !load_last && (words_loaded == LAST_SLOT)) begin
                    state_next = RUN;
                end
`else
                if (word_valid && (load_last || (words_loaded == LAST_SLOT))) begin
                    state_next = RUN;
                end
`endif
            end
            RUN: begin
                cpu_rst   = 1'b0;
                load_done = 1'b1;
                if (reload) begin
                    state_next = LOAD;
                    clear      = 1'b1;
                end
            end
            ERR: begin
                if (reload) begin
                    state_next = LOAD;
                    clear      = 1'b1;
                end
            end
            default: state_next = LOAD;
        endcase
    end

`ifdef IM_LOADER_CHECKSUM_EN
    assign chk_err = (state == ERR);

    // Running byte sum of the image and the flag marking that the next
    // accepted byte is the checksum rather than image data.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum         <= 8'h0;
            chk_pending <= 1'b0;
        end else begin
            if (image_byte) begin
                sum <= sum + load_data;
            end
            if (accept && chk_pending) begin
                chk_pending <= 1'b0;
            end else if (word_valid && load_last) begin
                chk_pending <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            words_loaded <= '0;
        end else if (word_valid) begin
            words_loaded <= words_loaded + 1'b1;
        end
    end

    // The array is never reset; stale contents are hidden by the
    // words_loaded gate on the read side.
    always_ff @(posedge clk) begin
        if (word_valid) begin
            mem[words_loaded[AW-1:0]] <= word_data;
        end
    end

    // Any address below words_loaded is necessarily below DEPTH, so the
    // narrow index is safe whenever the gate is open.
    always_comb begin
        Instruction = NOP_WORD;
        if ((state == RUN) && ({1'b0, IM_Address} < 17'(words_loaded))) begin
            Instruction = mem[IM_Address[AW-1:0]];
        end
    end

endmodule
